// File: rtl/vdc_cpu_port_master.sv
// CPU-side bus initiator for the HuC6270 VDC register port.
// A single-cycle register request becomes a sequence of byte accesses:
// an optional address-register write (A=00), then the data LSB (A=10) and
// data MSB (A=11), or a single status read (A=00).
// Each access is SETUP, then STROBE (stretched by BUSY_n), then HOLD.
module vdc_cpu_port_master #(
    parameter int STROBE_CYCLES = 2,
    parameter int BUSY_TIMEOUT  = 255,
    parameter int SKIP_AR       = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [4:0]  req_reg,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [15:0] rsp_rdata,
    output logic        CS_n,
    output logic        WR_n,
    output logic        RD_n,
    output logic [1:0]  A,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic [7:0]  D_in,
    input  logic        BUSY_n,
    output logic        EX_8_16
);

    localparam int SCW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [SCW-1:0] STR_LAST = SCW'(STROBE_CYCLES - 1);
    localparam logic [7:0]     EXT_MAX  = 8'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;
    typedef enum logic [1:0] {PH_ADDR, PH_LO, PH_HI, PH_STAT} phase_t;

    state_t         state_q, state_d;
    phase_t         phase_q, phase_d;
    logic           is_write_q, is_write_d;
    logic [4:0]     reg_q, reg_d;
    logic [15:0]    wdata_q, wdata_d;
    logic [15:0]    rdata_q, rdata_d;
    logic [SCW-1:0] str_cnt_q, str_cnt_d;
    logic [7:0]     ext_cnt_q, ext_cnt_d;
    logic           tmo_q, tmo_d;
    logic           ar_valid_q, ar_valid_d;
    logic [4:0]     ar_q, ar_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_err_q, rsp_err_d;
    logic [15:0]    rsp_rdata_q, rsp_rdata_d;

    logic min_done;
    logic strobe_exit;
    logic last_phase;
    logic ar_hit;
    logic access_write;

    // Strobe may only end after the minimum width, then only when the VDC is
    // ready or the busy extension has reached its limit.
    assign min_done    = (str_cnt_q == STR_LAST);
    assign strobe_exit = (state_q == ST_STROBE) && min_done &&
                         (BUSY_n || (ext_cnt_q == EXT_MAX));
    assign last_phase  = (phase_q == PH_HI) || (phase_q == PH_STAT);
    assign ar_hit      = (SKIP_AR != 0) && ar_valid_q && (ar_q == req_reg);
    // The address-register access is always a write; data phases follow the op.
    assign access_write = (phase_q == PH_ADDR) ||
                          (is_write_q && ((phase_q == PH_LO) || (phase_q == PH_HI)));

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: SETUP -> STROBE -> HOLD per access, chaining phases
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (req_valid) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: if (strobe_exit) state_d = ST_HOLD;
            ST_HOLD:   state_d = (last_phase || tmo_q) ? ST_IDLE : ST_SETUP;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Bus outputs decoded from state and phase; everything idles while in IDLE
    always_comb begin
        CS_n  = (state_q == ST_IDLE);
        WR_n  = 1'b1;
        RD_n  = 1'b1;
        A     = 2'b00;
        D_oe  = 1'b0;
        D_out = 8'h00;
        if (state_q != ST_IDLE) begin
            case (phase_q)
                PH_ADDR: A = 2'b00;
                PH_LO:   A = 2'b10;
                PH_HI:   A = 2'b11;
                default: A = 2'b00;
            endcase
            if (access_write) begin
                D_oe = 1'b1;
                case (phase_q)
                    PH_ADDR: D_out = {3'b000, reg_q};
                    PH_LO:   D_out = wdata_q[7:0];
                    PH_HI:   D_out = wdata_q[15:8];
                    default: D_out = 8'h00;
                endcase
            end
            if (state_q == ST_STROBE) begin
                WR_n = !access_write;
                RD_n = access_write;
            end
        end
    end

    // Datapath next state: request latch, strobe counters, read capture,
    // AR cache maintenance and response generation
    always_comb begin
        phase_d     = phase_q;
        is_write_d  = is_write_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        str_cnt_d   = str_cnt_q;
        ext_cnt_d   = ext_cnt_q;
        tmo_d       = tmo_q;
        ar_valid_d  = ar_valid_q;
        ar_d        = ar_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    is_write_d = (req_op == 2'b00);
                    reg_d      = req_reg;
                    wdata_d    = req_wdata;
                    rdata_d    = 16'h0000;
                    tmo_d      = 1'b0;
                    // Reserved op 11 behaves as a status read.
                    if (req_op[1])   phase_d = PH_STAT;
                    else if (ar_hit) phase_d = PH_LO;
                    else             phase_d = PH_ADDR;
                end
            end
            ST_SETUP: begin
                str_cnt_d = '0;
                ext_cnt_d = 8'h00;
            end
            ST_STROBE: begin
                if (strobe_exit) begin
                    tmo_d = !BUSY_n;
                    if (!access_write) begin
                        case (phase_q)
                            PH_LO:   rdata_d[7:0]  = D_in;
                            PH_HI:   rdata_d[15:8] = D_in;
                            PH_STAT: rdata_d       = {8'h00, D_in};
                            default: rdata_d       = rdata_q;
                        endcase
                    end
                end else if (!min_done) begin
                    str_cnt_d = str_cnt_q + 1'b1;
                end else begin
                    ext_cnt_d = ext_cnt_q + 8'h01;
                end
            end
            ST_HOLD: begin
                if (tmo_q) begin
                    ar_valid_d = 1'b0;
                end else if (phase_q == PH_ADDR) begin
                    ar_valid_d = 1'b1;
                    ar_d       = reg_q;
                end
                if (last_phase || tmo_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = tmo_q;
                    rsp_rdata_d = rdata_q;
                end else if (phase_q == PH_ADDR) begin
                    phase_d = PH_LO;
                end else begin
                    phase_d = PH_HI;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= PH_ADDR;
            is_write_q  <= 1'b0;
            reg_q       <= 5'h00;
            wdata_q     <= 16'h0000;
            rdata_q     <= 16'h0000;
            str_cnt_q   <= '0;
            ext_cnt_q   <= 8'h00;
            tmo_q       <= 1'b0;
            ar_valid_q  <= 1'b0;
            ar_q        <= 5'h00;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 16'h0000;
        end else begin
            phase_q     <= phase_d;
            is_write_q  <= is_write_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            str_cnt_q   <= str_cnt_d;
            ext_cnt_q   <= ext_cnt_d;
            tmo_q       <= tmo_d;
            ar_valid_q  <= ar_valid_d;
            ar_q        <= ar_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign EX_8_16   = 1'b1;

endmodule

// File: tb/tb_vdc_cpu_port_master.sv
// Self-checking bench for vdc_cpu_port_master: a vector table of register
// requests, a reference model of the byte accesses and responses, and
// scoreboards comparing the observed bus and response channel.
module tb_vdc_cpu_port_master;

    localparam int S = 2;
    localparam int T = 6;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [4:0]  req_reg;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [15:0] rsp_rdata;
    logic        CS_n, WR_n, RD_n;
    logic [1:0]  A;
    logic [7:0]  D_out;
    logic        D_oe;
    logic [7:0]  D_in;
    logic        BUSY_n;
    logic        EX_8_16;

    vdc_cpu_port_master #(
        .STROBE_CYCLES(S),
        .BUSY_TIMEOUT (T),
        .SKIP_AR      (1)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_reg  (req_reg),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_err  (rsp_err),
        .rsp_rdata(rsp_rdata),
        .CS_n     (CS_n),
        .WR_n     (WR_n),
        .RD_n     (RD_n),
        .A        (A),
        .D_out    (D_out),
        .D_oe     (D_oe),
        .D_in     (D_in),
        .BUSY_n   (BUSY_n),
        .EX_8_16  (EX_8_16)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  a;
        logic        wr;
        logic [7:0]  data;
        int          len;
    } acc_t;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          acc_cyc;
    } rsp_t;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  rg;
        logic [15:0] wd;
        int          ext;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [7:0]  st;
    } vec_t;

    acc_t exp_acc[$];
    rsp_t exp_rsp[$];

    int   checks = 0;
    int   errors = 0;
    int   busy_ext = 0;
    logic [7:0] din_lo = 8'h00, din_hi = 8'h00, din_st = 8'h00;
    bit   mon_en = 1'b1;
    bit   m_ar_valid = 1'b0;
    logic [4:0] m_ar = 5'h00;

    assign D_in = (A == 2'b10) ? din_lo : (A == 2'b11) ? din_hi : din_st;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // BUSY_n stimulus: low for the first S+busy_ext strobe cycles of every access;
    // outside a strobe it is driven low whenever busy is in use, which must be ignored.
    initial begin
        int k;
        k = 0;
        BUSY_n = 1'b1;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && (!WR_n || !RD_n)) begin
                k++;
                BUSY_n = !(k < S + busy_ext);
            end else begin
                k = 0;
                BUSY_n = (busy_ext == 0);
            end
        end
    end

    // Bus monitor: records each strobe and compares it with the model's next access
    initial begin
        acc_t cur;
        acc_t e;
        bit   in_acc;
        bit   ok;
        in_acc = 1'b0;
        ok     = 1'b1;
        cur    = '{a: 2'b00, wr: 1'b0, data: 8'h00, len: 0};
        forever begin
            @(negedge clock);
            if (reset_n !== 1'b1 || !mon_en) begin
                in_acc = 1'b0;
            end else if (!WR_n || !RD_n) begin
                if (!in_acc) begin
                    in_acc   = 1'b1;
                    cur.a    = A;
                    cur.wr   = !WR_n;
                    cur.data = D_out;
                    cur.len  = 1;
                    ok       = 1'b1;
                end else begin
                    cur.len++;
                end
                if (CS_n || (D_oe != !WR_n) || (A != cur.a) || (!WR_n && !RD_n)) ok = 1'b0;
            end else if (in_acc) begin
                in_acc = 1'b0;
                if (exp_acc.size() == 0) begin
                    chk("unexpected_access", {30'd0, cur.a}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_acc.pop_front();
                    $display("access A=%b %s data=%02h strobe=%0d", cur.a, cur.wr ? "WR" : "RD", cur.data, cur.len);
                    chk("acc_addr", {30'd0, cur.a}, {30'd0, e.a});
                    chk("acc_dir", {31'd0, cur.wr}, {31'd0, e.wr});
                    chk("acc_len", cur.len, e.len);
                    chk("acc_bus_ctl", {31'd0, ok}, 32'd1);
                    if (e.wr) chk("acc_data", {24'd0, cur.data}, {24'd0, e.data});
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every rsp_valid cycle
    initial begin
        rsp_t e;
        forever begin
            @(negedge clock);
            if (rsp_valid === 1'b1) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", {16'd0, rsp_rdata}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_rsp.pop_front();
                    $display("response rdata=%04h err=%0b latency=%0d", rsp_rdata, rsp_err, cyc - e.acc_cyc);
                    chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    chk("rsp_latency", cyc - e.acc_cyc, e.lat);
                end
            end
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("req_ready_timeout", 32'd0, 32'd1);
    endtask

    // Model the access sequence, push expectations, then present the request
    task automatic run_req(input vec_t v);
        bit          ok;
        int          len, n;
        logic        err;
        logic [15:0] rd;
        acc_t        a;
        rsp_t        r;
        wait_ready(ok);
        if (!ok) return;
        len = S + ((v.ext > T) ? T : v.ext);
        err = (v.ext > T);
        n   = 0;
        rd  = 16'h0000;
        if (v.op[1]) begin
            a = '{a: 2'b00, wr: 1'b0, data: 8'h00, len: len};
            exp_acc.push_back(a);
            n  = 1;
            rd = {8'h00, v.st};
        end else begin
            if (!(m_ar_valid && m_ar == v.rg)) begin
                a = '{a: 2'b00, wr: 1'b1, data: {3'b000, v.rg}, len: len};
                exp_acc.push_back(a);
                n++;
                if (!err) begin
                    m_ar_valid = 1'b1;
                    m_ar       = v.rg;
                end
            end
            if (!(err && n == 1)) begin
                a = '{a: 2'b10, wr: (v.op == 2'b00), data: v.wd[7:0], len: len};
                exp_acc.push_back(a);
                n++;
                if (v.op != 2'b00) rd[7:0] = v.lo;
                if (!err) begin
                    a = '{a: 2'b11, wr: (v.op == 2'b00), data: v.wd[15:8], len: len};
                    exp_acc.push_back(a);
                    n++;
                    if (v.op != 2'b00) rd[15:8] = v.hi;
                end
            end
        end
        if (err) m_ar_valid = 1'b0;
        r = '{rdata: rd, err: err, lat: n * (len + 2) + 1, acc_cyc: cyc};
        exp_rsp.push_back(r);
        busy_ext  = v.ext;
        din_lo    = v.lo;
        din_hi    = v.hi;
        din_st    = v.st;
        req_op    = v.op;
        req_reg   = v.rg;
        req_wdata = v.wd;
        req_valid = 1'b1;
        $display("request op=%b reg=%02h wdata=%04h busy_ext=%0d", v.op, v.rg, v.wd, v.ext);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_reg   = 5'($urandom);
        req_wdata = 16'($urandom);
    endtask

    vec_t vecs[12];

    initial begin
        bit ok;
        bit found;
        vecs[0]  = '{op: 2'b00, rg: 5'h05, wd: 16'h1234, ext: 0,   lo: 8'h00, hi: 8'h00, st: 8'h00};
        vecs[1]  = '{op: 2'b00, rg: 5'h05, wd: 16'hBEEF, ext: 0,   lo: 8'h00, hi: 8'h00, st: 8'h00};
        vecs[2]  = '{op: 2'b00, rg: 5'h06, wd: 16'h00A5, ext: 0,   lo: 8'h00, hi: 8'h00, st: 8'h00};
        vecs[3]  = '{op: 2'b01, rg: 5'h02, wd: 16'hFFFF, ext: 0,   lo: 8'hCD, hi: 8'hAB, st: 8'h00};
        vecs[4]  = '{op: 2'b01, rg: 5'h02, wd: 16'h0000, ext: 0,   lo: 8'h11, hi: 8'h22, st: 8'h00};
        vecs[5]  = '{op: 2'b10, rg: 5'h1F, wd: 16'h0000, ext: 5,   lo: 8'h00, hi: 8'h00, st: 8'h5A};
        vecs[6]  = '{op: 2'b01, rg: 5'h02, wd: 16'h0000, ext: 0,   lo: 8'h77, hi: 8'h66, st: 8'hEE};
        vecs[7]  = '{op: 2'b11, rg: 5'h03, wd: 16'h0000, ext: 0,   lo: 8'h00, hi: 8'h00, st: 8'h3C};
        vecs[8]  = '{op: 2'b00, rg: 5'h07, wd: 16'hCAFE, ext: 255, lo: 8'h00, hi: 8'h00, st: 8'h00};
        vecs[9]  = '{op: 2'b00, rg: 5'h07, wd: 16'hCAFE, ext: 0,   lo: 8'h00, hi: 8'h00, st: 8'h00};
        vecs[10] = '{op: 2'b00, rg: 5'h07, wd: 16'h5AA5, ext: T,   lo: 8'h00, hi: 8'h00, st: 8'h00};
        vecs[11] = '{op: 2'b01, rg: 5'h1C, wd: 16'h0000, ext: 1,   lo: 8'h0F, hi: 8'hF0, st: 8'h00};

        reset_n   = 1'b0;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_reg   = 5'h01;
        req_wdata = 16'h1111;
        repeat (3) @(negedge clock);
        chk("rst_cs_n", {31'd0, CS_n}, 32'd1);
        chk("rst_wr_n", {31'd0, WR_n}, 32'd1);
        chk("rst_rd_n", {31'd0, RD_n}, 32'd1);
        chk("rst_a", {30'd0, A}, 32'd0);
        chk("rst_d_out", {24'd0, D_out}, 32'd0);
        chk("rst_d_oe", {31'd0, D_oe}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("ex_8_16", {31'd0, EX_8_16}, 32'd1);
        req_valid = 1'b0;
        reset_n   = 1'b1;
        @(negedge clock);
        chk("idle_after_rst_cs_n", {31'd0, CS_n}, 32'd1);

        // Table vectors issued back-to-back: each request is presented as soon
        // as the previous one returns to idle (including its rsp_valid cycle).
        for (int i = 0; i < 12; i++) run_req(vecs[i]);

        // Reset asserted during the HI strobe of a write to an uncached register
        wait_ready(ok);
        mon_en    = 1'b0;
        busy_ext  = 0;
        req_op    = 2'b00;
        req_reg   = 5'h09;
        req_wdata = 16'h4321;
        req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (A == 2'b11 && !WR_n) begin
                found = 1'b1;
                break;
            end
        end
        chk("hi_strobe_reached", {31'd0, found}, 32'd1);
        reset_n = 1'b0;
        #1;
        $display("reset asserted mid-write: CS_n=%0b WR_n=%0b D_oe=%0b", CS_n, WR_n, D_oe);
        chk("async_rst_cs_n", {31'd0, CS_n}, 32'd1);
        chk("async_rst_wr_n", {31'd0, WR_n}, 32'd1);
        chk("async_rst_d_oe", {31'd0, D_oe}, 32'd0);
        chk("async_rst_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        m_ar_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (rsp_valid) chk("no_rsp_after_abort", {31'd0, rsp_valid}, 32'd0);
        end
        chk("ready_after_abort", {31'd0, req_ready}, 32'd1);
        mon_en = 1'b1;
        run_req('{op: 2'b00, rg: 5'h09, wd: 16'h8765, ext: 0, lo: 8'h00, hi: 8'h00, st: 8'h00});

        for (int i = 0; i < 200 && (exp_rsp.size() != 0 || exp_acc.size() != 0); i++)
            @(negedge clock);
        repeat (3) @(negedge clock);
        chk("pending_responses", exp_rsp.size(), 0);
        chk("pending_accesses", exp_acc.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
